// File: rtl/if_fetch_stage_pkg.sv
// if_fetch_stage_pkg: shared widths, reset values and FSM states for the fetch stage
package if_fetch_stage_pkg;
    localparam int PC_W    = 16;
    localparam int INSTR_W = 32;
    localparam logic [PC_W-1:0] RESET_PC = 16'h0000;
    localparam logic [PC_W-1:0] PC_STEP  = 16'd2;
    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALTED = 2'd2} state_t;
endpackage

// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: instruction-memory, control and IF/ID output signals of the fetch stage
interface if_fetch_stage_if;
    import if_fetch_stage_pkg::*;
    logic [PC_W-1:0]    imem_pc;
    logic [INSTR_W-1:0] imem_instr;
    logic               redirect_vld;
    logic [PC_W-1:0]    redirect_pc;
    logic               halt_req;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic               halted;
    logic [15:0]        fetch_cnt;
    modport master (
        output imem_pc, out_valid, out_instr, out_pc, halted, fetch_cnt,
        input  imem_instr, redirect_vld, redirect_pc, halt_req, out_ready
    );
    modport slave (
        input  imem_pc, out_valid, out_instr, out_pc, halted, fetch_cnt,
        output imem_instr, redirect_vld, redirect_pc, halt_req, out_ready
    );
endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// if_fetch_stage_if_id_reg: single-entry valid/ready holding register with flush
module if_fetch_stage_if_id_reg #(
    parameter int W = 48
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         flush,
    input  logic         ready,
    input  logic [W-1:0] in_data,
    output logic         valid,
    output logic [W-1:0] data
);
    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // flush beats load; an accepted entry with nothing new behind it drains
    always_comb begin
        valid_d = flush ? 1'b0 : load ? 1'b1 : (valid_q & ready) ? 1'b0 : valid_q;
        data_d  = (load & ~flush) ? in_data : data_q;
    end

    // entry storage, cleared immediately on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: program counter, fetch FSM and fetch counter feeding the IF/ID register
module if_fetch_stage
    import if_fetch_stage_pkg::*;
(
    input logic             clk,
    input logic             rst,
    if_fetch_stage_if.master bus
);
    state_t                     state_q, state_d;
    logic [PC_W-1:0]            pc_q, pc_d;
    logic [15:0]                cnt_q, cnt_d;
    logic                       fire;
    logic [PC_W+INSTR_W-1:0]    out_data;

    // redirect outranks halt, which outranks a normal fetch
    always_comb begin
        fire    = (state_q == RUN) & ~bus.redirect_vld & ~bus.halt_req & (~bus.out_valid | bus.out_ready);
        state_d = bus.redirect_vld ? RUN :
                  (state_q == BOOT) ? RUN :
                  (state_q == RUN && bus.halt_req) ? HALTED : state_q;
        pc_d    = bus.redirect_vld ? {bus.redirect_pc[PC_W-1:1], 1'b0} :
                  fire ? pc_q + PC_STEP : pc_q;
        cnt_d   = (fire && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end

    // stage state, returned to boot immediately on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    if_fetch_stage_if_id_reg #(.W(PC_W + INSTR_W)) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .load    (fire),
        .flush   (bus.redirect_vld),
        .ready   (bus.out_ready),
        .in_data ({pc_q, bus.imem_instr}),
        .valid   (bus.out_valid),
        .data    (out_data)
    );

    assign bus.imem_pc   = pc_q;
    assign bus.out_pc    = out_data[PC_W+INSTR_W-1:INSTR_W];
    assign bus.out_instr = out_data[INSTR_W-1:0];
    assign bus.halted    = (state_q == HALTED);
    assign bus.fetch_cnt = cnt_q;
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed scenarios plus random traffic against a behavioural fetch model
module tb_if_fetch_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    if_fetch_stage_if bus ();

    if_fetch_stage dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [31:0] rom [16];
    initial for (int i = 0; i < 16; i++) rom[i] = 32'hA000_0000 + 32'(i);
    assign bus.imem_instr = rom[bus.imem_pc[4:1]];

    logic [15:0] m_pc, m_out_pc, m_cnt;
    logic [31:0] m_out_instr;
    bit          m_valid, m_booting, m_halted;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_out_pc = 16'h0000; m_cnt = 16'h0000;
        m_out_instr = 32'h0; m_valid = 0; m_booting = 1; m_halted = 0;
    endtask

    task automatic cmp_all();
        chk("imem_pc",   64'(bus.imem_pc),   64'(m_pc));
        chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
        chk("out_pc",    64'(bus.out_pc),    64'(m_out_pc));
        chk("out_instr", 64'(bus.out_instr), 64'(m_out_instr));
        chk("halted",    64'(bus.halted),    64'(m_halted));
        chk("fetch_cnt", 64'(bus.fetch_cnt), 64'(m_cnt));
    endtask

    // apply inputs for one clock, advance the model, compare just after the edge
    task automatic step(input bit r, input logic [15:0] rpc, input bit h, input bit rdy);
        bit running, fire;
        bus.redirect_vld = r; bus.redirect_pc = rpc; bus.halt_req = h; bus.out_ready = rdy;
        running = !m_booting && !m_halted;
        fire = running && !r && !h && (!m_valid || rdy);
        @(posedge clk);
        if (r) begin
            m_pc = rpc & 16'hFFFE; m_valid = 0; m_booting = 0; m_halted = 0;
        end else begin
            if (fire) begin
                m_out_instr = 32'hA000_0000 + 32'((m_pc >> 1) % 16);
                m_out_pc = m_pc; m_valid = 1; m_pc = m_pc + 16'd2;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end else if (m_valid && rdy) m_valid = 0;
            if (m_booting) m_booting = 0;
            else if (running && h) m_halted = 1;
        end
        #1 cmp_all();
    endtask

    // reset asserted between edges must clear outputs without waiting for a clock
    task automatic mid_reset();
        #2 rst = 1'b1;
        #1;
        chk("async_valid", 64'(bus.out_valid), 64'd0);
        chk("async_pc",    64'(bus.imem_pc),   64'd0);
        chk("async_cnt",   64'(bus.fetch_cnt), 64'd0);
        model_reset();
        #2 rst = 1'b0;
    endtask

    initial begin
        bus.redirect_vld = 0; bus.redirect_pc = '0; bus.halt_req = 0; bus.out_ready = 1;
        model_reset();
        #3 rst = 1'b0;
        cmp_all();
        step(0, 0, 0, 1);
        chk("boot_pc", 64'(bus.imem_pc), 64'h0000);
        step(0, 0, 0, 1);
        chk("first_pc",    64'(bus.out_pc),    64'h0000);
        chk("first_instr", 64'(bus.out_instr), 64'hA000_0000);
        chk("first_imem",  64'(bus.imem_pc),   64'h0002);
        step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            chk("bp_out_pc", 64'(bus.out_pc),    64'h0002);
            chk("bp_imem",   64'(bus.imem_pc),   64'h0004);
            chk("bp_cnt",    64'(bus.fetch_cnt), 64'd2);
        end
        step(0, 0, 0, 1);
        chk("bp_release", 64'(bus.out_pc), 64'h0004);
        step(0, 0, 0, 0);
        step(1, 16'h0011, 0, 0);
        chk("rd_flush", 64'(bus.out_valid), 64'd0);
        chk("rd_imem",  64'(bus.imem_pc),   64'h0010);
        step(0, 0, 0, 0);
        chk("rd_out_pc", 64'(bus.out_pc),    64'h0010);
        chk("rd_instr",  64'(bus.out_instr), 64'hA000_0008);
        step(1, 16'h0004, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        chk("halt_on",   64'(bus.halted),    64'd1);
        chk("halt_held", 64'(bus.out_valid), 64'd1);
        step(0, 0, 0, 1);
        chk("halt_drain", 64'(bus.out_valid), 64'd0);
        step(0, 0, 0, 1);
        chk("halt_imem", 64'(bus.imem_pc), 64'h0006);
        step(1, 16'h0000, 0, 1);
        chk("halt_exit", 64'(bus.halted), 64'd0);
        step(0, 0, 0, 1);
        chk("resume_pc", 64'(bus.out_pc), 64'h0000);
        step(1, 16'hFFFE, 1, 1);
        chk("prio_halted", 64'(bus.halted), 64'd0);
        step(0, 0, 0, 1);
        chk("wrap_out_pc", 64'(bus.out_pc),  64'hFFFE);
        chk("wrap_imem",   64'(bus.imem_pc), 64'h0000);
        step(0, 0, 0, 1);
        mid_reset();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 19) == 0, 16'($urandom), $urandom_range(0, 14) == 0,
                 $urandom_range(0, 9) < 7);
            if ($urandom_range(0, 99) == 0) mid_reset();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
